mem_access_unit: RTL and testbench
==================================

# mem_access_unit

Memory-access stage of the 5-stage pipeline, between the EX/MEM register and the `MEM` (MEM/WB) register. It performs loads and stores over a single-outstanding request/ack data bus and handles byte-lane alignment and load sign/zero extension. It produces the write-back triple `wD`/`wR`/`rf_we` and the pipeline-wide `pause`. Non-memory instructions pass through combinationally with no stall.

## Interface
- `TIMEOUT_CYC`, default 255: WAIT cycles without ack before the access is aborted.
- `clk_i`  in  1  clock.
- `rst_i`  in  1  reset, asynchronous, active-high.
- `valid_i`  in  1  EX/MEM holds a valid instruction.
- `mem_en_i`  in  1  instruction accesses memory.
- `mem_we_i`  in  1  1 = store, 0 = load.
- `mem_size_i`  in  2  00 byte, 01 half, 10 word; 11 is treated as word.
- `mem_uns_i`  in  1  load zero-extends (1) or sign-extends (0).
- `addr_i`  in  32  ALU result; byte address.
- `sdata_i`  in  32  store data.
- `wD_i`  in  32  non-memory write-back data.
- `wR_i`  in  5  destination register.
- `rf_we_i`  in  1  register-file write enable.
- `wD_o`  out  32  write-back data to MEM/WB.
- `wR_o`  out  5  destination register to MEM/WB.
- `rf_we_o`  out  1  write enable to MEM/WB.
- `stall_o`  out  1  drives `pause` of all upstream stages and of MEM/WB.
- `bus_req_o`  out  1  request valid.
- `bus_we_o`  out  1  write request.
- `bus_addr_o`  out  32  word address ({addr[31:2],2'b00}).
- `bus_wdata_o`  out  32  lane-replicated store data.
- `bus_be_o`  out  4  byte enables.
- `bus_ack_i`  in  1  access complete; `bus_rdata_i` valid this cycle.
- `bus_rdata_i`  in  32  read data.
- `misalign_o`  out  1  misaligned access, combinational.
- `timeout_o`  out  1  one-cycle pulse on abort.

## Operation
- FSM states are IDLE, WAIT and DONE.
- **Accept:** in IDLE, `valid_i & mem_en_i & aligned` accepts the access.
  - Latches addr, be, wdata, we, size, uns, wR and rf_we.
  - Asserts `stall_o` combinationally.
  - Moves to WAIT and clears the timeout counter.
- **WAIT:**
  - `bus_req_o=1`, `stall_o=1`; bus outputs are driven from latched values and are stable.
  - `bus_ack_i` captures formatted load data and moves to DONE.
  - Otherwise the counter increments. When the counter equals `TIMEOUT_CYC-1` with no ack, the access aborts: `timeout_o=1`, load data=0, `rf_we` is suppressed, and the FSM moves to DONE.
  - If ack and the timeout condition occur in the same cycle, ack wins.
- **DONE:**
  - `stall_o=0` and `bus_req_o=0`.
  - Outputs: `wD_o`=latched load data, `wR_o`=latched wR, `rf_we_o`=latched rf_we & ~store & ~aborted.
  - Always returns to IDLE. DONE never re-accepts, because the same instruction is still at the inputs.
- **Alignment:**
  - Half requires addr[0]=0; word requires addr[1:0]=0.
  - A misaligned access gives `misalign_o=1`, no bus request, no stall, and `rf_we_o=0`.
- **Byte lanes (little-endian):**
  - be: byte = 4'b0001<<addr[1:0], half = 4'b0011<<addr[1:0], word = 4'b1111.
  - wdata: byte = {4{sdata[7:0]}}, half = {2{sdata[15:0]}}, word = sdata.
- **Load format:** lane = `bus_rdata_i` >> (8*addr[1:0]); take [7:0] or [15:0] and sign- or zero-extend to 32 bits.
- **Pass-through:** in IDLE with no memory op, `wD_o=wD_i`, `wR_o=wR_i`, `rf_we_o=rf_we_i & valid_i`, `stall_o=0`.
- `bus_ack_i` in IDLE or DONE is ignored.

## Timing
- **Reset values:** state IDLE, counter 0, all latches 0.
  - `bus_req_o=0`, `timeout_o=0`, `stall_o=0`.
  - `wD_o` is 0, `wR_o` is 0, `rf_we_o` is 0 while `rst_i` is high.
- **Minimum latency:** ack in the first WAIT cycle gives 3 cycles in the stage: accept, WAIT, DONE. Two cycles are stalled. MEM/WB captures at the end of DONE.
- Each additional ack wait cycle adds one cycle of latency.
- **Reset mid-access:** `bus_req_o` drops asynchronously, the FSM goes to IDLE, and no write-back occurs.
- **Bus protocol:** one outstanding request. `bus_req_o` stays high until ack or abort and is never re-asserted in the cycle after ack.

## Structure
- Shared package `cpu_pkg` holds:
  - size codes SZ_BYTE/SZ_HALF/SZ_WORD;
  - state enum MA_IDLE/MA_WAIT/MA_DONE;
  - default TIMEOUT_CYC.
- One sub-module, `mem_lane_align`: combinational be/wdata generation plus load shift and extend, parameter-free.

## Test plan
- **Word load:** addr 0x100, ack in the first WAIT cycle with rdata 0xDEADBEEF -> stall for 2 cycles; in DONE `wD_o`=0xDEADBEEF and `rf_we_o`=1.
- **Signed byte load:** addr 0x103, rdata 0x80112233 -> `wD_o`=0xFFFFFF80. The same load unsigned -> 0x00000080.
- **Half store:** addr 0x102, sdata 0x0000ABCD -> be=4'b1100, wdata=0xABCDABCD, `rf_we_o`=0 in DONE.
- **Misaligned word load:** addr 0x101 -> `misalign_o`=1, no `bus_req_o`, `stall_o`=0, `rf_we_o`=0.
- **Timeout:** `TIMEOUT_CYC`=4 with no ack -> abort after the 4th WAIT cycle; `timeout_o` is a single pulse and `rf_we_o`=0.
- **Reset mid-access:** assert `rst_i` in the 2nd WAIT cycle -> `bus_req_o`=0 immediately. After release, a pass-through ALU instruction gives `wD_o`=`wD_i` with no stall.

Source files
------------

// File: rtl/cpu_pkg.sv
// Shared pipeline definitions: memory access size codes, MEM-stage FSM states,
// the latched request record and the alignment rule.
package cpu_pkg;

    localparam logic [1:0] SZ_BYTE = 2'b00;
    localparam logic [1:0] SZ_HALF = 2'b01;
    localparam logic [1:0] SZ_WORD = 2'b10;

    localparam int TIMEOUT_CYC_DEF = 255;

    typedef enum logic [1:0] {
        MA_IDLE = 2'd0,
        MA_WAIT = 2'd1,
        MA_DONE = 2'd2
    } ma_state_e;

    typedef struct packed {
        logic [31:0] addr;
        logic [31:0] sdata;
        logic        we;
        logic [1:0]  size;
        logic        uns;
        logic [4:0]  wr;
        logic        rf_we;
    } ma_req_t;

    // Size code 11 behaves as a word access.
    function automatic logic addr_ok(input logic [1:0] size, input logic [1:0] lo);
        case (size)
            SZ_BYTE: return 1'b1;
            SZ_HALF: return ~lo[0];
            default: return (lo == 2'b00);
        endcase
    endfunction

endpackage

// File: rtl/mem_lane_align.sv
// Little-endian byte-lane steering: store byte enables / replicated write data,
// and load lane extraction with sign or zero extension.
module mem_lane_align
    import cpu_pkg::*;
(
    input  logic [1:0]  size,
    input  logic        uns,
    input  logic [1:0]  addr_lo,
    input  logic [31:0] sdata,
    input  logic [31:0] rdata,
    output logic [3:0]  be,
    output logic [31:0] wdata,
    output logic [31:0] ldata
);

    logic [31:0] lane;

    assign lane = rdata >> {addr_lo, 3'b000};

    always_comb begin
        be    = 4'b1111;
        wdata = sdata;
        ldata = rdata;
        case (size)
            SZ_BYTE: begin
                be    = 4'b0001 << addr_lo;
                wdata = {4{sdata[7:0]}};
                ldata = {{24{~uns & lane[7]}}, lane[7:0]};
            end
            SZ_HALF: begin
                be    = 4'b0011 << addr_lo;
                wdata = {2{sdata[15:0]}};
                ldata = {{16{~uns & lane[15]}}, lane[15:0]};
            end
            default: ;
        endcase
    end

endmodule

// File: rtl/mem_access_unit.sv
// MEM stage: single-outstanding load/store over a req/ack bus, stalling the
// pipeline while the access is in flight; non-memory ops pass straight through.
module mem_access_unit
    import cpu_pkg::*;
#(
    parameter int TIMEOUT_CYC = TIMEOUT_CYC_DEF
) (
    input  logic        clk_i,
    input  logic        rst_i,
    input  logic        valid_i,
    input  logic        mem_en_i,
    input  logic        mem_we_i,
    input  logic [1:0]  mem_size_i,
    input  logic        mem_uns_i,
    input  logic [31:0] addr_i,
    input  logic [31:0] sdata_i,
    input  logic [31:0] wD_i,
    input  logic [4:0]  wR_i,
    input  logic        rf_we_i,
    output logic [31:0] wD_o,
    output logic [4:0]  wR_o,
    output logic        rf_we_o,
    output logic        stall_o,
    output logic        bus_req_o,
    output logic        bus_we_o,
    output logic [31:0] bus_addr_o,
    output logic [31:0] bus_wdata_o,
    output logic [3:0]  bus_be_o,
    input  logic        bus_ack_i,
    input  logic [31:0] bus_rdata_i,
    output logic        misalign_o,
    output logic        timeout_o
);

    localparam int             CW       = $clog2(TIMEOUT_CYC + 1);
    localparam logic [CW-1:0]  TMO_LAST = CW'(TIMEOUT_CYC - 1);

    ma_state_e   st, nxt;
    ma_req_t     req_q;
    logic [CW-1:0] cnt;
    logic [31:0] ld_q, ld_fmt;
    logic        abort_q, aligned, accept, tmo_hit;
    logic [31:0] wd;
    logic [4:0]  wr;
    logic        we, stall, req;

    assign aligned    = addr_ok(mem_size_i, addr_i[1:0]);
    assign misalign_o = valid_i & mem_en_i & ~aligned;
    assign accept     = (st == MA_IDLE) & valid_i & mem_en_i & aligned;
    // Ack in the same cycle as the last allowed wait wins over the abort.
    assign tmo_hit    = (st == MA_WAIT) & ~bus_ack_i & (cnt == TMO_LAST);
    assign timeout_o  = tmo_hit;

    mem_lane_align u_align (
        .size    (req_q.size),
        .uns     (req_q.uns),
        .addr_lo (req_q.addr[1:0]),
        .sdata   (req_q.sdata),
        .rdata   (bus_rdata_i),
        .be      (bus_be_o),
        .wdata   (bus_wdata_o),
        .ldata   (ld_fmt)
    );

    assign bus_we_o   = req_q.we;
    assign bus_addr_o = {req_q.addr[31:2], 2'b00};

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) st <= MA_IDLE;
        else       st <= nxt;
    end

    always_comb begin
        nxt   = st;
        stall = 1'b0;
        req   = 1'b0;
        wd    = wD_i;
        wr    = wR_i;
        we    = rf_we_i & valid_i;
        case (st)
            MA_IDLE: begin
                if (valid_i & mem_en_i) begin
                    we = 1'b0;
                    if (aligned) begin
                        stall = 1'b1;
                        nxt   = MA_WAIT;
                    end
                end
            end
            MA_WAIT: begin
                stall = 1'b1;
                req   = 1'b1;
                wd    = ld_q;
                wr    = req_q.wr;
                we    = 1'b0;
                if (bus_ack_i | tmo_hit) nxt = MA_DONE;
            end
            MA_DONE: begin
                wd  = ld_q;
                wr  = req_q.wr;
                we  = req_q.rf_we & ~req_q.we & ~abort_q;
                nxt = MA_IDLE;
            end
            default: nxt = MA_IDLE;
        endcase
    end

    // Write-back outputs are forced quiet while reset is held.
    assign stall_o   = stall & ~rst_i;
    assign bus_req_o = req & ~rst_i;
    assign wD_o      = rst_i ? 32'd0 : wd;
    assign wR_o      = rst_i ? 5'd0 : wr;
    assign rf_we_o   = we & ~rst_i;

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            req_q   <= '0;
            cnt     <= '0;
            ld_q    <= '0;
            abort_q <= 1'b0;
        end else if (accept) begin
            req_q.addr  <= addr_i;
            req_q.sdata <= sdata_i;
            req_q.we    <= mem_we_i;
            req_q.size  <= mem_size_i;
            req_q.uns   <= mem_uns_i;
            req_q.wr    <= wR_i;
            req_q.rf_we <= rf_we_i;
            cnt         <= '0;
            abort_q     <= 1'b0;
        end else if (st == MA_WAIT) begin
            if (bus_ack_i) begin
                ld_q <= ld_fmt;
            end else if (tmo_hit) begin
                ld_q    <= '0;
                abort_q <= 1'b1;
            end else begin
                cnt <= cnt + 1'b1;
            end
        end
    end

endmodule

// File: tb/tb_mem_access_unit.sv
// Randomized bench for mem_access_unit against a transaction-level model of
// the MEM stage (alignment, lanes, extension, latency, timeout, reset).
module tb_mem_access_unit;

    localparam int TMO = 4;

    logic        clk = 1'b0;
    logic        rst_i;
    logic        valid_i, mem_en_i, mem_we_i, mem_uns_i, rf_we_i;
    logic [1:0]  mem_size_i;
    logic [31:0] addr_i, sdata_i, wD_i, bus_rdata_i;
    logic [4:0]  wR_i;
    logic        bus_ack_i;
    logic [31:0] wD_o, bus_addr_o, bus_wdata_o;
    logic [4:0]  wR_o;
    logic        rf_we_o, stall_o, bus_req_o, bus_we_o, misalign_o, timeout_o;
    logic [3:0]  bus_be_o;

    int n_chk  = 0;
    int n_fail = 0;

    always #5 clk = ~clk;

    mem_access_unit #(.TIMEOUT_CYC(TMO)) dut (
        .clk_i(clk), .rst_i(rst_i), .valid_i(valid_i), .mem_en_i(mem_en_i),
        .mem_we_i(mem_we_i), .mem_size_i(mem_size_i), .mem_uns_i(mem_uns_i),
        .addr_i(addr_i), .sdata_i(sdata_i), .wD_i(wD_i), .wR_i(wR_i),
        .rf_we_i(rf_we_i), .wD_o(wD_o), .wR_o(wR_o), .rf_we_o(rf_we_o),
        .stall_o(stall_o), .bus_req_o(bus_req_o), .bus_we_o(bus_we_o),
        .bus_addr_o(bus_addr_o), .bus_wdata_o(bus_wdata_o), .bus_be_o(bus_be_o),
        .bus_ack_i(bus_ack_i), .bus_rdata_i(bus_rdata_i),
        .misalign_o(misalign_o), .timeout_o(timeout_o)
    );

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_chk++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s got=%h exp=%h at %0t", tag, got, exp, $time);
        end
    endtask

    function automatic bit is_aligned(input logic [1:0] sz, input logic [31:0] a);
        if (sz == 2'd0) return 1'b1;
        if (sz == 2'd1) return (a % 2) == 0;
        return (a % 4) == 0;
    endfunction

    function automatic logic [31:0] exp_load(input logic [1:0] sz, input bit uns,
                                             input logic [31:0] a, input logic [31:0] rd);
        logic [31:0] v;
        v = rd / (32'd1 << (8 * (a % 4)));
        if (sz == 2'd0) begin
            v = v % 32'h100;
            if (!uns && v >= 32'h80) v = v + 32'hFFFF_FF00;
        end else if (sz == 2'd1) begin
            v = v % 32'h1_0000;
            if (!uns && v >= 32'h8000) v = v + 32'hFFFF_0000;
        end
        return v;
    endfunction

    function automatic logic [31:0] exp_be(input logic [1:0] sz, input logic [31:0] a);
        if (sz == 2'd0) return 32'd1 << (a % 4);
        if (sz == 2'd1) return 32'd3 << (a % 4);
        return 32'hF;
    endfunction

    function automatic logic [31:0] exp_wdata(input logic [1:0] sz, input logic [31:0] sd);
        if (sz == 2'd0) return (sd % 32'h100) * 32'h0101_0101;
        if (sz == 2'd1) return (sd % 32'h1_0000) * 32'h0001_0001;
        return sd;
    endfunction

    // dly: WAIT cycle index at which ack arrives; >= TMO means never.
    task automatic mem_op(input bit we, input logic [1:0] sz, input bit uns,
                          input logic [31:0] a, input logic [31:0] sd, input logic [31:0] rd,
                          input logic [4:0] wr, input bit rfw, input int dly);
        bit acked = 1'b0;
        @(negedge clk);
        valid_i = 1'b1; mem_en_i = 1'b1; mem_we_i = we; mem_size_i = sz; mem_uns_i = uns;
        addr_i = a; sdata_i = sd; wR_i = wr; rf_we_i = rfw; wD_i = $urandom;
        bus_ack_i = 1'b0; bus_rdata_i = $urandom;
        #1;
        if (!is_aligned(sz, a)) begin
            check("mis_flag", 32'(misalign_o), 32'd1);
            check("mis_req", 32'(bus_req_o), 32'd0);
            check("mis_stall", 32'(stall_o), 32'd0);
            check("mis_rfwe", 32'(rf_we_o), 32'd0);
            return;
        end
        check("acc_mis", 32'(misalign_o), 32'd0);
        check("acc_stall", 32'(stall_o), 32'd1);
        check("acc_req", 32'(bus_req_o), 32'd0);
        check("acc_rfwe", 32'(rf_we_o), 32'd0);
        for (int k = 0; k < TMO; k++) begin
            @(negedge clk);
            bus_ack_i = (k == dly); bus_rdata_i = rd;
            #1;
            check("wait_req", 32'(bus_req_o), 32'd1);
            check("wait_stall", 32'(stall_o), 32'd1);
            check("wait_addr", bus_addr_o, a - (a % 4));
            check("wait_we", 32'(bus_we_o), 32'(we));
            check("wait_be", 32'(bus_be_o), exp_be(sz, a));
            if (we) check("wait_wdata", bus_wdata_o, exp_wdata(sz, sd));
            check("wait_tmo", 32'(timeout_o), 32'((k == TMO - 1) && (k != dly)));
            if (k == dly) begin
                acked = 1'b1;
                break;
            end
        end
        @(negedge clk);
        bus_ack_i = 1'b0; bus_rdata_i = $urandom;
        #1;
        check("done_stall", 32'(stall_o), 32'd0);
        check("done_req", 32'(bus_req_o), 32'd0);
        check("done_tmo", 32'(timeout_o), 32'd0);
        check("done_wr", 32'(wR_o), 32'(wr));
        check("done_rfwe", 32'(rf_we_o), 32'(rfw && !we && acked));
        if (!we) check("done_wd", wD_o, acked ? exp_load(sz, uns, a, rd) : 32'd0);
    endtask

    task automatic pass_op(input bit v, input bit rfw, input bit ack);
        logic [31:0] d;
        logic [4:0]  r;
        d = $urandom; r = 5'($urandom_range(0, 31));
        @(negedge clk);
        valid_i = v; mem_en_i = 1'b0; mem_we_i = 1'($urandom_range(0, 1));
        addr_i = $urandom; wD_i = d; wR_i = r; rf_we_i = rfw; bus_ack_i = ack;
        #1;
        check("pt_wd", wD_o, d);
        check("pt_wr", 32'(wR_o), 32'(r));
        check("pt_rfwe", 32'(rf_we_o), 32'(v & rfw));
        check("pt_stall", 32'(stall_o), 32'd0);
        check("pt_req", 32'(bus_req_o), 32'd0);
    endtask

    initial begin
        rst_i = 1'b1; valid_i = 1'b1; mem_en_i = 1'b0; mem_we_i = 1'b0; mem_uns_i = 1'b0;
        mem_size_i = 2'd2; addr_i = '0; sdata_i = '0; wD_i = 32'h1234_5678; wR_i = 5'd7;
        rf_we_i = 1'b1; bus_ack_i = 1'b0; bus_rdata_i = '0;
        #2;
        check("rst_wd", wD_o, 32'd0);
        check("rst_wr", 32'(wR_o), 32'd0);
        check("rst_rfwe", 32'(rf_we_o), 32'd0);
        check("rst_stall", 32'(stall_o), 32'd0);
        check("rst_req", 32'(bus_req_o), 32'd0);
        check("rst_tmo", 32'(timeout_o), 32'd0);
        @(negedge clk); @(negedge clk);
        rst_i = 1'b0; valid_i = 1'b0;

        // Directed cases
        mem_op(0, 2'd2, 0, 32'h100, 32'h0, 32'hDEAD_BEEF, 5'd3, 1, 0);
        mem_op(0, 2'd0, 0, 32'h103, 32'h0, 32'h8011_2233, 5'd4, 1, 0);
        mem_op(0, 2'd0, 1, 32'h103, 32'h0, 32'h8011_2233, 5'd4, 1, 1);
        mem_op(1, 2'd1, 0, 32'h102, 32'h0000_ABCD, 32'h0, 5'd5, 1, 0);
        mem_op(0, 2'd2, 0, 32'h101, 32'h0, 32'h0, 5'd6, 1, 0);
        mem_op(0, 2'd2, 0, 32'h104, 32'h0, 32'h5555_AAAA, 5'd8, 1, TMO);
        mem_op(0, 2'd1, 0, 32'h106, 32'h0, 32'hF00F_1234, 5'd9, 1, TMO - 1);
        pass_op(1, 1, 1);
        pass_op(0, 1, 0);

        // Reset in the second WAIT cycle
        @(negedge clk);
        valid_i = 1'b1; mem_en_i = 1'b1; mem_we_i = 1'b0; mem_size_i = 2'd2;
        addr_i = 32'h200; rf_we_i = 1'b1; wR_i = 5'd10; bus_ack_i = 1'b0;
        #1 check("rm_acc_stall", 32'(stall_o), 32'd1);
        @(negedge clk); #1 check("rm_w1_req", 32'(bus_req_o), 32'd1);
        @(negedge clk); #1 check("rm_w2_req", 32'(bus_req_o), 32'd1);
        rst_i = 1'b1;
        #1;
        check("rm_req", 32'(bus_req_o), 32'd0);
        check("rm_stall", 32'(stall_o), 32'd0);
        check("rm_rfwe", 32'(rf_we_o), 32'd0);
        @(negedge clk);
        rst_i = 1'b0; valid_i = 1'b0;
        pass_op(1, 1, 0);
        @(negedge clk); #1 check("rm_post_req", 32'(bus_req_o), 32'd0);

        // Random mix
        for (int i = 0; i < 120; i++) begin
            if ($urandom_range(0, 3) == 0) begin
                pass_op(1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)));
            end else begin
                logic [1:0]  sz;
                logic [31:0] a;
                sz = 2'($urandom_range(0, 3));
                a  = $urandom;
                if ($urandom_range(0, 3) != 0) begin
                    if (sz == 2'd1) a = a - (a % 2);
                    else if (sz != 2'd0) a = a - (a % 4);
                end
                mem_op(1'($urandom_range(0, 1)), sz, 1'($urandom_range(0, 1)), a,
                       $urandom, $urandom, 5'($urandom_range(0, 31)),
                       1'($urandom_range(0, 1)), $urandom_range(0, TMO));
            end
        end

        $display("TB_RESULT checks=%0d failures=%0d", n_chk, n_fail);
        $finish;
    end

endmodule
